// File: rtl/ipml_fifo_rd_stream_pkg.sv
// Shared constants and width helpers for the FIFO read-side stream adapter.
package ipml_fifo_rd_stream_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ipml_fifo_rd_stream_if.sv
// FIFO raw read port plus valid/ready output stream, bundled for the adapter.
interface ipml_fifo_rd_stream_if #(
    parameter int W     = 8,
    parameter int LVL_W = 2
);
    logic             fifo_rd_empty;
    logic             fifo_rd_en;
    logic [W-1:0]     fifo_rd_data;
    logic             data_out_ready;
    logic             data_out_valid;
    logic [W-1:0]     data_out;
    logic [LVL_W-1:0] buf_level;

    modport master (
        input  fifo_rd_empty, fifo_rd_data, data_out_ready,
        output fifo_rd_en, data_out_valid, data_out, buf_level
    );

    modport slave (
        output fifo_rd_empty, fifo_rd_data, data_out_ready,
        input  fifo_rd_en, data_out_valid, data_out, buf_level
    );
endinterface

// File: rtl/ipml_fifo_rd_buf.sv
// Circular register buffer: push at wptr, show-ahead head at rptr, occupancy count.
module ipml_fifo_rd_buf
    import ipml_fifo_rd_stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int LVL_W = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     data_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o
);
    localparam int               PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] occ_q, occ_d;
    logic             do_pop;

    assign valid_o = (occ_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign data_o  = mem_q[rptr_q];
    assign level_o = occ_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push_i) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        if (push_i && !do_pop) begin
            occ_d = occ_q + LVL_W'(1);
        end else if (!push_i && do_pop) begin
            occ_d = occ_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (push_i && (wptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ipml_fifo_rd_stream.sv
// Credit-limited prefetching reader: turns the FIFO raw read port into a show-ahead stream.
module ipml_fifo_rd_stream
    import ipml_fifo_rd_stream_pkg::*;
#(
    parameter int W         = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = RD_LAT + 1
) (
    input  logic clk,
    input  logic rst,
    ipml_fifo_rd_stream_if.master bus
);
    localparam int LVL_W = lvl_w(BUF_DEPTH);
    localparam int CNT_W = clog2(BUF_DEPTH + RD_LAT + 2);

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("RD_LAT must be 1 or 2");
        end
        if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
            $error("BUF_DEPTH must be at least RD_LAT+1");
        end
    endgenerate

    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]  infl;
    logic [LVL_W-1:0]  level;
    logic [W-1:0]      head;
    logic              valid;
    logic              pop;
    logic              push;
    logic              credit_ok;
    logic              rd_en;

    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl = infl + CNT_W'(pipe_q[i]);
        end
    end

    // occ + infl - pop < BUF_DEPTH, rearranged to avoid unsigned underflow.
    assign pop       = valid & bus.data_out_ready;
    assign credit_ok = (CNT_W'(level) + infl) < (CNT_W'(BUF_DEPTH) + CNT_W'(pop));
    assign rd_en     = ~bus.fifo_rd_empty & ~rst & credit_ok;
    assign push      = pipe_q[RD_LAT-1];

    assign pipe_d = RD_LAT'({pipe_q, rd_en});

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    ipml_fifo_rd_buf #(
        .W     (W),
        .DEPTH (BUF_DEPTH),
        .LVL_W (LVL_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (bus.fifo_rd_data),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (valid),
        .level_o (level)
    );

    assign bus.fifo_rd_en     = rd_en;
    assign bus.data_out_valid = valid;
    assign bus.data_out       = head;
    assign bus.buf_level      = level;

endmodule

// File: tb/tb_ipml_fifo_rd_stream.sv
// Two adapters (RD_LAT=1/depth 2 and RD_LAT=2/depth 3) against a queue-level FIFO+stream model.
module tb_ipml_fifo_rd_stream;
    import ipml_fifo_rd_stream_pkg::*;

    localparam int W   = 8;
    localparam int L0  = 1;
    localparam int L1  = 2;
    localparam int D0  = 2;
    localparam int D1  = 3;
    localparam int LW0 = lvl_w(D0);
    localparam int LW1 = lvl_w(D1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipml_fifo_rd_stream_if #(.W(W), .LVL_W(LW0)) if0 ();
    ipml_fifo_rd_stream_if #(.W(W), .LVL_W(LW1)) if1 ();

    ipml_fifo_rd_stream #(.W(W), .RD_LAT(L0), .BUF_DEPTH(D0)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    ipml_fifo_rd_stream #(.W(W), .RD_LAT(L1), .BUF_DEPTH(D1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

    logic         empty_s [2];
    logic [W-1:0] rdata_s [2];
    logic         ready_s;
    logic         rden_w  [2];
    logic         valid_w [2];
    logic [W-1:0] dout_w  [2];
    int           lvl_o   [2];

    assign if0.fifo_rd_empty  = empty_s[0];
    assign if0.fifo_rd_data   = rdata_s[0];
    assign if0.data_out_ready = ready_s;
    assign if1.fifo_rd_empty  = empty_s[1];
    assign if1.fifo_rd_data   = rdata_s[1];
    assign if1.data_out_ready = ready_s;
    assign rden_w[0]  = if0.fifo_rd_en;
    assign rden_w[1]  = if1.fifo_rd_en;
    assign valid_w[0] = if0.data_out_valid;
    assign valid_w[1] = if1.data_out_valid;
    assign dout_w[0]  = if0.data_out;
    assign dout_w[1]  = if1.data_out;
    assign lvl_o[0]   = int'(if0.buf_level);
    assign lvl_o[1]   = int'(if1.buf_level);

    // Model: FIFO contents, reads awaiting return, and the words the consumer should see.
    logic [W-1:0] mem   [2][256];
    int           wrp   [2];
    int           rdp   [2];
    logic [W-1:0] ebuf  [2][64];
    int           eh    [2];
    int           et    [2];
    logic [W-1:0] pword [2][64];
    int           pdue  [2][64];
    bit           plive [2][64];
    int           ph    [2];
    int           pt    [2];

    int cyc;
    int nw;
    bit block_empty;
    bit seen_rst;
    bit in_rst;
    int total;
    int bad;

    int first_rd [2];
    int first_v  [2];
    int first_pop[2];
    int last_pop [2];
    int npop     [2];
    int nrd      [2];
    int maxlvl   [2];
    int viol     [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 0) ? D0 : D1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                mem[d][wrp[d] % 256] = W'(nw);
                wrp[d]++;
            end
            nw++;
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            first_rd[d]  = -1;
            first_v[d]   = -1;
            first_pop[d] = -1;
            last_pop[d]  = -1;
            npop[d]      = 0;
            nrd[d]       = 0;
            maxlvl[d]    = 0;
            viol[d]      = 0;
        end
    endtask

    function automatic int live_count(input int d);
        int n;
        n = 0;
        for (int i = ph[d]; i < pt[d]; i++) begin
            if (plive[d][i % 64]) n++;
        end
        return n;
    endfunction

    task automatic step(input bit r, input bit rdy);
        int  ecnt;
        int  infl;
        bit  pop;
        bit  exp_en [2];
        rst     = r;
        ready_s = rdy;
        for (int d = 0; d < 2; d++) begin
            empty_s[d] = (wrp[d] == rdp[d]) || block_empty;
            if (ph[d] < pt[d] && pdue[d][ph[d] % 64] == cyc) begin
                rdata_s[d] = pword[d][ph[d] % 64];
            end else begin
                rdata_s[d] = W'($urandom);
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            ecnt = et[d] - eh[d];
            infl = live_count(d);
            pop  = (ecnt > 0) && rdy;
            exp_en[d] = !r && !empty_s[d] && ((ecnt + infl - int'(pop)) < dep_of(d));
            chk($sformatf("rd_en%0d", d), 32'(rden_w[d]), 32'(exp_en[d]));
            if (seen_rst) begin
                chk($sformatf("valid%0d", d), 32'(valid_w[d]), 32'(ecnt > 0));
                chk($sformatf("level%0d", d), lvl_o[d], ecnt);
                if (ecnt > 0) begin
                    chk($sformatf("data%0d", d), 32'(dout_w[d]), 32'(ebuf[d][eh[d] % 64]));
                end
            end
            if (in_rst) begin
                chk($sformatf("rst_data%0d", d), 32'(dout_w[d]), 0);
            end
            if (rden_w[d] === 1'b1) begin
                nrd[d]++;
                if (first_rd[d] < 0) first_rd[d] = cyc;
                if (empty_s[d]) viol[d]++;
            end
            if (valid_w[d] === 1'b1) begin
                if (first_v[d] < 0) first_v[d] = cyc;
                if (rdy && !r) begin
                    npop[d]++;
                    if (first_pop[d] < 0) first_pop[d] = cyc;
                    last_pop[d] = cyc;
                end
            end
            if (lvl_o[d] > maxlvl[d]) maxlvl[d] = lvl_o[d];

            if (r) begin
                for (int i = ph[d]; i < pt[d]; i++) plive[d][i % 64] = 1'b0;
                eh[d] = et[d];
            end else if (pop) begin
                eh[d]++;
            end
            while (ph[d] < pt[d] && pdue[d][ph[d] % 64] == cyc) begin
                if (plive[d][ph[d] % 64] && !r) begin
                    chk($sformatf("push_room%0d", d), 32'(lvl_o[d] < dep_of(d)), 1);
                    ebuf[d][et[d] % 64] = pword[d][ph[d] % 64];
                    et[d]++;
                end
                ph[d]++;
            end
            if (exp_en[d]) begin
                pword[d][pt[d] % 64] = mem[d][rdp[d] % 256];
                pdue[d][pt[d] % 64]  = cyc + lat_of(d);
                plive[d][pt[d] % 64] = 1'b1;
                pt[d]++;
                rdp[d]++;
            end
        end
        in_rst = r;
        if (r) seen_rst = 1'b1;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        ready_s = 1'b0;
        block_empty = 1'b0;
        seen_rst = 1'b0;
        in_rst = 1'b0;
        cyc = 0;
        total = 0;
        bad = 0;
        nw = 1;
        for (int d = 0; d < 2; d++) begin
            wrp[d] = 0; rdp[d] = 0; eh[d] = 0; et[d] = 0; ph[d] = 0; pt[d] = 0;
            empty_s[d] = 1'b1;
            rdata_s[d] = '0;
            for (int i = 0; i < 64; i++) begin
                plive[d][i] = 1'b0;
                pdue[d][i]  = -1;
            end
        end
        clear_stats();

        // Reset with a non-empty FIFO: no reads may be issued.
        load_words(16);
        repeat (3) step(1'b1, 1'b1);

        // Streaming 0x01..0x10 with ready held high.
        clear_stats();
        repeat (30) step(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("first_lat%0d", d), first_v[d] - first_rd[d], lat_of(d) + 1);
            chk($sformatf("stream_beats%0d", d), npop[d], 16);
            chk($sformatf("stream_gapless%0d", d), last_pop[d] - first_pop[d], 15);
        end

        // Backpressure: credit stops reads once the buffer is committed.
        nw = 1;
        load_words(10);
        clear_stats();
        repeat (8) step(1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("bp_reads%0d", d), nrd[d], dep_of(d));
            chk($sformatf("bp_level%0d", d), lvl_o[d], dep_of(d));
            chk($sformatf("bp_head%0d", d), 32'(dout_w[d]), 32'h01);
        end
        repeat (20) step(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) chk($sformatf("bp_drain%0d", d), npop[d], 10);

        // Full buffer with alternating ready: simultaneous push/pop and pointer wrap.
        load_words(40);
        clear_stats();
        repeat (6) step(1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'(i % 2));
        repeat (20) step(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("alt_maxlvl%0d", d), 32'(maxlvl[d] <= dep_of(d)), 1);
            chk($sformatf("alt_count%0d", d), npop[d], 40);
        end

        // Empty flag toggling every 3 cycles with random ready.
        load_words(30);
        clear_stats();
        for (int i = 0; i < 120; i++) begin
            block_empty = ((i / 3) % 2) == 1;
            step(1'b0, 1'($urandom % 4 != 0));
        end
        block_empty = 1'b0;
        repeat (20) step(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("empty_gate%0d", d), viol[d], 0);
            chk($sformatf("empty_count%0d", d), npop[d], 30);
        end

        // Reset while two reads are outstanding; late returns must be dropped.
        load_words(20);
        clear_stats();
        k = 0;
        while (live_count(1) != 2 && k < 10) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("inflight2", live_count(1), 2);
        block_empty = 1'b1;
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mid_rst_valid%0d", d), 32'(valid_w[d]), 0);
            chk($sformatf("mid_rst_level%0d", d), lvl_o[d], 0);
        end
        block_empty = 1'b0;
        repeat (30) step(1'b0, 1'b1);
        for (int d = 0; d < 2; d++) chk($sformatf("final_idle%0d", d), 32'(valid_w[d]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
